// File: rtl/bidir_link_io_ctrl.sv
// Per-channel bidirectional pad controller for a 4-phase req/ack parallel link.
// Direction changes wait for an idle handshake, then tristate all pads, then settle the synchronisers.
module bidir_link_io_ctrl #(
  parameter int CHANNELS    = 4,
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = 2,
  parameter int TURN_CYCLES = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [CHANNELS-1:0]        en,
  input  logic [CHANNELS-1:0]        dir_req,
  output logic [CHANNELS-1:0]        link_rdy,
  output logic [CHANNELS-1:0]        dir_cur,
  inout  wire  [CHANNELS-1:0]        acknowledge,
  inout  wire  [CHANNELS-1:0]        request,
  inout  wire  [CHANNELS*DATA_W-1:0] pdata,
  input  logic [CHANNELS-1:0]        REQ_SEND,
  input  logic [CHANNELS*DATA_W-1:0] DAT_SEND,
  output logic [CHANNELS-1:0]        ACK_SEND,
  input  logic [CHANNELS-1:0]        ACK_RECV,
  output logic [CHANNELS-1:0]        REQ_RECV,
  output logic [CHANNELS*DATA_W-1:0] DAT_RECV
);

  localparam int CNT_MAX = (TURN_CYCLES > SYNC_STAGES) ? TURN_CYCLES : SYNC_STAGES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TURN_LD = CW'(TURN_CYCLES);
  localparam logic [CW-1:0] SYNC_LD = CW'(SYNC_STAGES);
  localparam logic [CW-1:0] ONE     = CW'(1);

  typedef enum logic [2:0] {OFF, TURN, SETTLE, TX, RX} state_t;

  for (genvar ch = 0; ch < CHANNELS; ch++) begin : g_ch
    state_t                         state_q, state_d;
    logic                           tgt_q, tgt_d;
    logic [CW-1:0]                  cnt_q, cnt_d;
    logic                           rdy_q, rdy_d;
    logic                           dir_q, dir_d;
    logic [SYNC_STAGES-1:0]         ack_sync_q, req_sync_q;
    logic [SYNC_STAGES-1:0][DATA_W-1:0] dat_sync_q;
    logic                           drive_tx, drive_rx;
    logic                           ack_o, req_o;
    logic [DATA_W-1:0]              dat_o;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state_q    <= OFF;
        tgt_q      <= 1'b0;
        cnt_q      <= '0;
        rdy_q      <= 1'b0;
        dir_q      <= 1'b0;
        ack_sync_q <= '0;
        req_sync_q <= '0;
        dat_sync_q <= '0;
      end else begin
        state_q    <= state_d;
        tgt_q      <= tgt_d;
        cnt_q      <= cnt_d;
        rdy_q      <= rdy_d;
        dir_q      <= dir_d;
        // Index 0 samples the pad; the oldest stage feeds the core.
        ack_sync_q <= {ack_sync_q[SYNC_STAGES-2:0], acknowledge[ch]};
        req_sync_q <= {req_sync_q[SYNC_STAGES-2:0], request[ch]};
        dat_sync_q <= {dat_sync_q[SYNC_STAGES-2:0], pdata[ch*DATA_W +: DATA_W]};
      end
    end

    always_comb begin
      state_d = state_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      case (state_q)
        OFF: begin
          if (en[ch]) begin
            state_d = TURN;
            tgt_d   = dir_req[ch];
            cnt_d   = TURN_LD;
          end
        end
        TURN: begin
          if (cnt_q <= ONE) begin
            state_d = en[ch] ? SETTLE : OFF;
            cnt_d   = en[ch] ? SYNC_LD : '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        SETTLE: begin
          // No handshake can be in flight yet, so a disable turns around at once.
          if (!en[ch]) begin
            state_d = TURN;
            cnt_d   = TURN_LD;
          end else if (cnt_q <= ONE) begin
            state_d = tgt_q ? RX : TX;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
        TX: begin
          if ((!en[ch] || dir_req[ch]) && !REQ_SEND[ch] && !ack_sync_q[SYNC_STAGES-1]) begin
            state_d = TURN;
            tgt_d   = dir_req[ch];
            cnt_d   = TURN_LD;
          end
        end
        RX: begin
          if ((!en[ch] || !dir_req[ch]) && !req_sync_q[SYNC_STAGES-1] && !ACK_RECV[ch]) begin
            state_d = TURN;
            tgt_d   = dir_req[ch];
            cnt_d   = TURN_LD;
          end
        end
        default: begin
          state_d = OFF;
          cnt_d   = '0;
        end
      endcase
      rdy_d = (state_d == TX) || (state_d == RX);
      dir_d = (state_d == RX);
    end

    always_comb begin
      drive_tx = (state_q == TX) || ((state_q == SETTLE) && !tgt_q);
      drive_rx = (state_q == RX) || ((state_q == SETTLE) && tgt_q);
      ack_o    = (state_q == TX) && ack_sync_q[SYNC_STAGES-1];
      req_o    = (state_q == RX) && req_sync_q[SYNC_STAGES-1];
      dat_o    = (state_q == RX) ? dat_sync_q[SYNC_STAGES-1] : '0;
    end

    assign request[ch]                   = drive_tx ? REQ_SEND[ch] : 1'bz;
    assign pdata[ch*DATA_W +: DATA_W]    = drive_tx ? DAT_SEND[ch*DATA_W +: DATA_W] : {DATA_W{1'bz}};
    assign acknowledge[ch]               = drive_rx ? ACK_RECV[ch] : 1'bz;
    assign ACK_SEND[ch]                  = ack_o;
    assign REQ_RECV[ch]                  = req_o;
    assign DAT_RECV[ch*DATA_W +: DATA_W] = dat_o;
    assign link_rdy[ch]                  = rdy_q;
    assign dir_cur[ch]                   = dir_q;
  end

endmodule

// File: tb/tb_bidir_link_io_ctrl.sv
// Directed bench for bidir_link_io_ctrl: default instance plus a 2x8, 3-stage sync, 1-turn instance.
// Undriven req/data pads are pulled high and ack pads pulled low so Hi-Z is observable.
module tb_bidir_link_io_ctrl;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   en, dir_req, REQ_SEND, ACK_RECV;
  logic [127:0] DAT_SEND;
  wire  [3:0]   link_rdy, dir_cur, ACK_SEND, REQ_RECV;
  wire  [127:0] DAT_RECV;
  tri0  [3:0]   acknowledge;
  tri1  [3:0]   request;
  tri1  [127:0] pdata;

  logic [3:0]   tb_req_oe, tb_req_v, tb_ack_oe, tb_ack_v, tb_dat_oe;
  logic [127:0] tb_dat_v;

  logic [1:0]   s_en, s_dir_req, s_req_send, s_ack_recv;
  logic [15:0]  s_dat_send;
  wire  [1:0]   s_link_rdy, s_dir_cur, s_ack_send, s_req_recv;
  wire  [15:0]  s_dat_recv;
  tri0  [1:0]   s_acknowledge;
  tri1  [1:0]   s_request;
  tri1  [15:0]  s_pdata;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  for (genvar i = 0; i < 4; i++) begin : g_rem
    assign request[i]        = tb_req_oe[i] ? tb_req_v[i] : 1'bz;
    assign acknowledge[i]    = tb_ack_oe[i] ? tb_ack_v[i] : 1'bz;
    assign pdata[i*32 +: 32] = tb_dat_oe[i] ? tb_dat_v[i*32 +: 32] : {32{1'bz}};
  end

  bidir_link_io_ctrl u_dut (
    .clk(clk), .rst(rst), .en(en), .dir_req(dir_req),
    .link_rdy(link_rdy), .dir_cur(dir_cur),
    .acknowledge(acknowledge), .request(request), .pdata(pdata),
    .REQ_SEND(REQ_SEND), .DAT_SEND(DAT_SEND), .ACK_SEND(ACK_SEND),
    .ACK_RECV(ACK_RECV), .REQ_RECV(REQ_RECV), .DAT_RECV(DAT_RECV)
  );

  bidir_link_io_ctrl #(.CHANNELS(2), .DATA_W(8), .SYNC_STAGES(3), .TURN_CYCLES(1)) u_small (
    .clk(clk), .rst(rst), .en(s_en), .dir_req(s_dir_req),
    .link_rdy(s_link_rdy), .dir_cur(s_dir_cur),
    .acknowledge(s_acknowledge), .request(s_request), .pdata(s_pdata),
    .REQ_SEND(s_req_send), .DAT_SEND(s_dat_send), .ACK_SEND(s_ack_send),
    .ACK_RECV(s_ack_recv), .REQ_RECV(s_req_recv), .DAT_RECV(s_dat_recv)
  );

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    step(2);
    n_tests++; if (link_rdy !== 4'h0) begin n_fail++; $display("FAIL reset_link_rdy got=%b exp=0000", link_rdy); end
    n_tests++; if (dir_cur !== 4'h0) begin n_fail++; $display("FAIL reset_dir_cur got=%b exp=0000", dir_cur); end
    n_tests++; if ({ACK_SEND, REQ_RECV} !== 8'h00) begin n_fail++; $display("FAIL reset_ack_req got=%b exp=0", {ACK_SEND, REQ_RECV}); end
    n_tests++; if (DAT_RECV !== 128'h0) begin n_fail++; $display("FAIL reset_dat_recv got=%h exp=0", DAT_RECV); end
    n_tests++; if (request !== 4'hF) begin n_fail++; $display("FAIL reset_req_hiz got=%b exp=1111", request); end
    n_tests++; if (pdata !== {128{1'b1}}) begin n_fail++; $display("FAIL reset_pdata_hiz got=%h exp=all ones", pdata); end
    n_tests++; if (s_pdata !== 16'hFFFF || s_link_rdy !== 2'b00) begin n_fail++; $display("FAIL reset_small got=%h/%b exp=ffff/00", s_pdata, s_link_rdy); end
  endtask

  task automatic test_bringup();
    logic        drv;
    logic [3:0]  exp_rdy;
    en = 4'b0001; dir_req = 4'b0000; REQ_SEND = 4'h0; DAT_SEND = '0;
    rst = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      step(1);
      drv     = (c >= 3);
      exp_rdy = (c == 5) ? 4'b0001 : 4'b0000;
      n_tests++; if (request[0] !== !drv) begin n_fail++; $display("FAIL bringup_req c=%0d got=%b exp=%b", c, request[0], !drv); end
      n_tests++; if (pdata[31:0] !== (drv ? 32'h0 : 32'hFFFF_FFFF)) begin n_fail++; $display("FAIL bringup_pdata c=%0d got=%h drv=%b", c, pdata[31:0], drv); end
      n_tests++; if (link_rdy !== exp_rdy) begin n_fail++; $display("FAIL bringup_rdy c=%0d got=%b exp=%b", c, link_rdy, exp_rdy); end
      n_tests++; if (request[3:1] !== 3'b111) begin n_fail++; $display("FAIL bringup_idle_ch c=%0d got=%b exp=111", c, request[3:1]); end
    end
    n_tests++; if (dir_cur[0] !== 1'b0) begin n_fail++; $display("FAIL bringup_dir got=%b exp=0", dir_cur[0]); end
    REQ_SEND[0] = 1'b1; DAT_SEND[31:0] = 32'h1234_5678;
    #1;
    n_tests++; if (pdata[31:0] !== 32'h1234_5678) begin n_fail++; $display("FAIL tx_data got=%h exp=12345678", pdata[31:0]); end
  endtask

  task automatic test_tx_busy_turn();
    logic exp_rdy;
    tb_ack_oe[0] = 1'b1; tb_ack_v[0] = 1'b1; dir_req[0] = 1'b1;
    step(3);
    n_tests++; if (link_rdy[0] !== 1'b1 || dir_cur[0] !== 1'b0) begin n_fail++; $display("FAIL busy_hold rdy=%b dir=%b exp=1/0", link_rdy[0], dir_cur[0]); end
    n_tests++; if (ACK_SEND[0] !== 1'b1) begin n_fail++; $display("FAIL busy_ack_send got=%b exp=1", ACK_SEND[0]); end
    REQ_SEND[0] = 1'b0;
    step(3);
    n_tests++; if (link_rdy[0] !== 1'b1 || request[0] !== 1'b0) begin n_fail++; $display("FAIL busy_ack_hold rdy=%b req=%b exp=1/0", link_rdy[0], request[0]); end
    tb_ack_oe[0] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      exp_rdy = (k <= 2) || (k == 7);
      n_tests++; if (link_rdy[0] !== exp_rdy) begin n_fail++; $display("FAIL turn_rdy k=%0d got=%b exp=%b", k, link_rdy[0], exp_rdy); end
      if (k == 2) begin
        n_tests++; if (ACK_SEND[0] !== 1'b0) begin n_fail++; $display("FAIL turn_ack_drop got=%b exp=0", ACK_SEND[0]); end
      end
      if (k == 3 || k == 4) begin
        n_tests++; if (request[0] !== 1'b1 || pdata[31:0] !== 32'hFFFF_FFFF) begin n_fail++; $display("FAIL turn_hiz k=%0d req=%b dat=%h exp=1/ffffffff", k, request[0], pdata[31:0]); end
      end
      if (k == 4) begin
        tb_req_oe[0] = 1'b1; tb_req_v[0] = 1'b0;
        tb_dat_oe[0] = 1'b1; tb_dat_v[31:0] = 32'h0;
      end
    end
    n_tests++; if (dir_cur[0] !== 1'b1) begin n_fail++; $display("FAIL turn_dir got=%b exp=1", dir_cur[0]); end
  endtask

  task automatic test_rx_data();
    tb_req_v[0] = 1'b1; tb_dat_v[31:0] = 32'hDEAD_BEEF;
    step(1);
    n_tests++; if (REQ_RECV[0] !== 1'b0 || DAT_RECV[31:0] !== 32'h0) begin n_fail++; $display("FAIL rx_early req=%b dat=%h exp=0/0", REQ_RECV[0], DAT_RECV[31:0]); end
    step(1);
    n_tests++; if (REQ_RECV[0] !== 1'b1 || DAT_RECV[31:0] !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL rx_data req=%b dat=%h exp=1/deadbeef", REQ_RECV[0], DAT_RECV[31:0]); end
    tb_dat_v[31:0] = 32'h0F0F_A5A5;
    step(2);
    n_tests++; if (DAT_RECV[31:0] !== 32'h0F0F_A5A5) begin n_fail++; $display("FAIL rx_data2 got=%h exp=0f0fa5a5", DAT_RECV[31:0]); end
    ACK_RECV[0] = 1'b1;
    #1;
    n_tests++; if (acknowledge[0] !== 1'b1) begin n_fail++; $display("FAIL rx_ack_pad got=%b exp=1", acknowledge[0]); end
    step(3);
    n_tests++; if (ACK_SEND[0] !== 1'b0) begin n_fail++; $display("FAIL rx_ack_send_mask got=%b exp=0", ACK_SEND[0]); end
    ACK_RECV[0] = 1'b0;
    #1;
    n_tests++; if (acknowledge[0] !== 1'b0) begin n_fail++; $display("FAIL rx_ack_pad_low got=%b exp=0", acknowledge[0]); end
  endtask

  task automatic test_stale_turn();
    logic exp_rdy, exp_rr;
    tb_req_oe[2] = 1'b1; tb_req_v[2] = 1'b1;
    en[2] = 1'b1; dir_req[2] = 1'b1;
    step(5);
    n_tests++; if (link_rdy[2] !== 1'b1 || dir_cur[2] !== 1'b1 || REQ_RECV[2] !== 1'b1) begin n_fail++; $display("FAIL ch2_rx rdy=%b dir=%b rr=%b exp=1/1/1", link_rdy[2], dir_cur[2], REQ_RECV[2]); end
    dir_req[2] = 1'b0;
    step(2);
    n_tests++; if (link_rdy[2] !== 1'b1 || dir_cur[2] !== 1'b1) begin n_fail++; $display("FAIL ch2_busy rdy=%b dir=%b exp=1/1", link_rdy[2], dir_cur[2]); end
    tb_req_v[2] = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      step(1);
      exp_rdy = (k <= 2) || (k == 7);
      exp_rr  = (k == 1);
      n_tests++; if (link_rdy[2] !== exp_rdy) begin n_fail++; $display("FAIL ch2_rdy k=%0d got=%b exp=%b", k, link_rdy[2], exp_rdy); end
      n_tests++; if (REQ_RECV[2] !== exp_rr) begin n_fail++; $display("FAIL ch2_req_recv k=%0d got=%b exp=%b", k, REQ_RECV[2], exp_rr); end
      n_tests++; if (ACK_SEND[2] !== (k == 7)) begin n_fail++; $display("FAIL ch2_ack_send k=%0d got=%b exp=%b", k, ACK_SEND[2], (k == 7)); end
      if (k == 3) begin
        tb_req_v[2] = 1'b1; tb_ack_oe[2] = 1'b1; tb_ack_v[2] = 1'b1;
      end
      if (k == 4) tb_req_oe[2] = 1'b0;
      if (k == 5) begin
        n_tests++; if (request[2] !== 1'b0) begin n_fail++; $display("FAIL ch2_settle_drive got=%b exp=0", request[2]); end
      end
    end
    n_tests++; if (dir_cur[2] !== 1'b0) begin n_fail++; $display("FAIL ch2_dir_tx got=%b exp=0", dir_cur[2]); end
  endtask

  task automatic test_reset_mid_settle();
    tb_req_oe = 4'h0; tb_dat_oe = 4'h0; tb_ack_oe = 4'h0;
    ACK_RECV[0] = 1'b1; REQ_SEND = 4'h0; DAT_SEND = '0;
    en[1] = 1'b1; dir_req[1] = 1'b0;
    step(3);
    n_tests++; if (request[1] !== 1'b0 || pdata[63:32] !== 32'h0) begin n_fail++; $display("FAIL ch1_settle req=%b dat=%h exp=0/0", request[1], pdata[63:32]); end
    n_tests++; if (acknowledge[0] !== 1'b1 || REQ_RECV[0] !== 1'b1) begin n_fail++; $display("FAIL pre_rst ack=%b rr=%b exp=1/1", acknowledge[0], REQ_RECV[0]); end
    rst = 1'b1;
    #1;
    n_tests++; if (request !== 4'hF || pdata !== {128{1'b1}}) begin n_fail++; $display("FAIL rst_pads req=%b dat=%h exp=1111/all ones", request, pdata); end
    n_tests++; if (acknowledge !== 4'h0) begin n_fail++; $display("FAIL rst_ack_pad got=%b exp=0000", acknowledge); end
    n_tests++; if ({link_rdy, dir_cur, ACK_SEND, REQ_RECV} !== 16'h0) begin n_fail++; $display("FAIL rst_outs got=%h exp=0", {link_rdy, dir_cur, ACK_SEND, REQ_RECV}); end
    n_tests++; if (DAT_RECV !== 128'h0) begin n_fail++; $display("FAIL rst_dat_recv got=%h exp=0", DAT_RECV); end
    en = 4'h0; ACK_RECV = 4'h0;
    step(1);
    rst = 1'b0;
    step(6);
    n_tests++; if (link_rdy !== 4'h0 || request[1] !== 1'b1) begin n_fail++; $display("FAIL post_rst_off rdy=%b req1=%b exp=0000/1", link_rdy, request[1]); end
  endtask

  task automatic test_small_abort();
    logic [7:0] exp_lo;
    logic [1:0] exp_rdy;
    s_en = 2'b01; s_dir_req = 2'b00; s_req_send = 2'b00; s_dat_send = 16'h0;
    for (int k = 1; k <= 9; k++) begin
      step(1);
      exp_rdy = (k == 9) ? 2'b01 : 2'b00;
      exp_lo  = (k == 2 || k == 6 || k == 7 || k == 8 || k == 9) ? 8'h00 : 8'hFF;
      n_tests++; if (s_pdata[15:8] !== 8'hFF) begin n_fail++; $display("FAIL small_ch1_hiz k=%0d got=%h exp=ff", k, s_pdata[15:8]); end
      n_tests++; if (s_pdata[7:0] !== exp_lo) begin n_fail++; $display("FAIL small_ch0_pad k=%0d got=%h exp=%h", k, s_pdata[7:0], exp_lo); end
      n_tests++; if (s_link_rdy !== exp_rdy) begin n_fail++; $display("FAIL small_rdy k=%0d got=%b exp=%b", k, s_link_rdy, exp_rdy); end
      if (k == 2) s_en = 2'b00;
      if (k == 4) s_en = 2'b01;
    end
  endtask

  initial begin
    rst = 1'b1;
    en = '0; dir_req = '0; REQ_SEND = '0; ACK_RECV = '0; DAT_SEND = '0;
    tb_req_oe = '0; tb_req_v = '0; tb_ack_oe = '0; tb_ack_v = '0; tb_dat_oe = '0; tb_dat_v = '0;
    s_en = '0; s_dir_req = '0; s_req_send = '0; s_ack_recv = '0; s_dat_send = '0;
    test_reset();
    test_bringup();
    test_tx_busy_turn();
    test_rx_data();
    test_stale_turn();
    test_reset_mid_settle();
    test_small_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
